noc_packetizer: RTL
===================

# noc_packetizer

Network-interface stage that sits directly upstream of a mesh node's local injection port (`data_in`/`valid_in`/`ready_in`). It accepts a destination command and a stream of payload words, then emits one wormhole packet of `FlitPerPacket` flits: one head, `FlitPerPacket-2` body flits and one tail. Each flit has a 2-bit type field in its MSBs. The output is a registered valid/ready port that connects straight to the router's input 0.

## Interface
- `N`, 4: node count in the mesh; `DW = $clog2(N)`.
- `INDEX`, 0: this node's id, placed in head flit as source.
- `DATA_WIDTH`, 32: flit width.
- `TYPE_WIDTH`, 2: type field width, located at `[DATA_WIDTH-1 -: TYPE_WIDTH]`.
- `FlitPerPacket`, 6: flits per packet; must be ≥ 2.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_dest` in DW: destination node id.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake; one command starts one packet.
- `pl_data` in `DATA_WIDTH-TYPE_WIDTH`: payload word.
- `pl_valid` in 1, `pl_ready` out 1: payload handshake; `FlitPerPacket-1` words per packet.
- `data_out` out DATA_WIDTH, `valid_out` out 1, `ready_out` in 1: flit output to the router.
- `busy` out 1: high from head acceptance until the tail is loaded.
- `pkt_count` out 16: number of tail flits transferred out, wrapping.

## Operation
- Type codes: 2'b01 head, 2'b10 body, 2'b11 tail. Code 2'b00 is never emitted.
- Head payload: `[DW-1:0]` = dest, `[2*DW-1:DW]` = INDEX, all other bits zero (see Configuration).
- Body and tail payload: `pl_data` verbatim in `[DATA_WIDTH-TYPE_WIDTH-1:0]`.
- Output register free condition: `out_free = !valid_out || ready_out`.
- FSM state IDLE:
  - `cmd_ready = out_free`, `pl_ready = 0`.
  - On a cmd handshake: load the head flit, clear `cnt`, go to PAYLOAD.
- FSM state PAYLOAD:
  - `cmd_ready = 0`, `pl_ready = out_free`.
  - On each pl handshake: load a body flit if `cnt < FlitPerPacket-2`, otherwise load the tail flit and go to IDLE.
  - `cnt` increments on each pl handshake.
- Output register:
  - When no load occurs and `ready_out` is high, `valid_out` clears.
  - While `valid_out && !ready_out`, `data_out` is held stable.
- `dest == INDEX` is legal and is forwarded unchanged.
- `pkt_count` increments when `valid_out && ready_out` and the output type is tail. It wraps from 0xFFFF to 0.
- `FlitPerPacket == 2`: the first payload word becomes the tail directly.

## Timing
- Reset values: `valid_out=0`, `data_out=0`, `cmd_ready=0`, `pl_ready=0`, `busy=0`, `pkt_count=0`, FSM=IDLE, `cnt=0`. Outputs assert from the first cycle after release.
- Latency: a handshake at edge t drives `valid_out`/`data_out` visible right after t (one register stage).
- Throughput: one flit per cycle while `ready_out` and the inputs stay high. A full packet takes `FlitPerPacket` cycles.
- `cmd_ready`/`pl_ready` depend combinationally on `ready_out`. There is no combinational path from `cmd_valid`/`pl_valid` to `valid_out`.
- Back-to-back packets: a cmd handshake is allowed in the cycle right after the tail is loaded.
- Reset mid-packet: state clears immediately and the partial packet is discarded. The system resets routers on the same `rst`.
- Backpressure: `ready_out` low for k cycles stalls all input handshakes for k cycles. No flit is lost or duplicated.

## Configuration
- `PACKETIZER_SEQNUM_EN` defined:
  - Head bits `[23:16]` carry an 8-bit sequence number, reset 0.
  - The number increments on each head load and wraps 255→0.
  - Requires `DATA_WIDTH-TYPE_WIDTH ≥ 24`.
- `PACKETIZER_SEQNUM_EN` undefined: those bits are zero and no counter exists.

## Test plan
- Reset, then cmd dest=3 (INDEX=0) and payload 0x11..0x55 with `ready_out`=1 → `data_out` sequence 0x40000003, 0x80000011, 0x80000022, 0x80000033, 0x80000044, 0xC0000055 on 6 consecutive cycles; `pkt_count`=1.
- Same packet with `ready_out` low for 3 cycles after the second flit → that flit is held stable; no handshake occurs; the sequence is otherwise identical.
- Two commands back-to-back (dest 1, then dest 2) with continuous payload → 12 flits, no idle cycle; head2 = 0x40000002.
- Assert `rst` after the 3rd flit → `valid_out` drops asynchronously. The next command yields a clean head and `pkt_count` stays 0.
- With `PACKETIZER_SEQNUM_EN`, send 257 packets → the 257th head has bits[23:16]=0x00; `pkt_count`=257.
- `FlitPerPacket=2`, dest=0 with INDEX=0, payload 0x7 → flits 0x40000000 then 0xC0000007.

Source files
------------

// File: rtl/noc_packetizer.sv
// ---------------------------------------------------------------------------
// noc_packetizer
//
// Network-interface stage in front of a mesh node's local injection port.
// It takes one destination command plus FlitPerPacket-1 payload words and
// emits one wormhole packet: head, FlitPerPacket-2 body flits, then a tail.
// The flit type sits in the top TYPE_WIDTH bits:
//   01 = head, 10 = body, 11 = tail.
// The output is a single register stage with a valid/ready handshake.
//
// Optional feature (compile-time macro PACKETIZER_SEQNUM_EN):
//   When defined, head bits [23:16] carry an 8-bit sequence number. It
//   starts at 0 and advances on every head load, wrapping 255 -> 0. This
//   needs DATA_WIDTH-TYPE_WIDTH >= 24. When the macro is undefined those
//   bits are zero and no counter is built.
//
// Ports:
//   clk, rst   : rising-edge clock; asynchronous active-high reset
//   cmd_dest   : destination node id for the next packet
//   cmd_valid  : command handshake in
//   cmd_ready  : command handshake out
//   pl_data    : payload word, copied verbatim into body/tail flits
//   pl_valid   : payload handshake in
//   pl_ready   : payload handshake out
//   data_out   : registered flit to the router
//   valid_out  : flit valid to the router
//   ready_out  : router ready
//   busy       : a packet is open (head accepted, tail not yet loaded)
//   pkt_count  : wrapping count of tail flits transferred out
// ---------------------------------------------------------------------------
module noc_packetizer #(
  parameter  int N             = 4,
  parameter  int INDEX         = 0,
  parameter  int DATA_WIDTH    = 32,
  parameter  int TYPE_WIDTH    = 2,
  parameter  int FlitPerPacket = 6,
  localparam int DW            = (N > 1) ? $clog2(N) : 1,
  localparam int PW            = DATA_WIDTH - TYPE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         cmd_dest,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [PW-1:0]         pl_data,
  input  logic                  pl_valid,
  output logic                  pl_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic                  busy,
  output logic [15:0]           pkt_count
);

  // cnt only has to reach FlitPerPacket-1.
  localparam int CW = (FlitPerPacket > 2) ? $clog2(FlitPerPacket) : 1;
  localparam logic [CW-1:0] LAST_BODY = CW'(FlitPerPacket - 2);

  localparam logic [TYPE_WIDTH-1:0] T_HEAD = TYPE_WIDTH'(2'b01);
  localparam logic [TYPE_WIDTH-1:0] T_BODY = TYPE_WIDTH'(2'b10);
  localparam logic [TYPE_WIDTH-1:0] T_TAIL = TYPE_WIDTH'(2'b11);

  typedef enum logic {S_IDLE, S_PAYLOAD} state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [15:0]           r_pkt_count;

  logic                  w_out_free;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_flit;
  logic                  w_cmd_ready;
  logic                  w_pl_ready;
  logic [PW-1:0]         w_head_pl;
  logic                  w_tail_xfer;

  // Ready outputs are held low during reset; out_free would otherwise be 1
  // because valid_out is cleared.
  assign w_out_free = (!r_valid || ready_out) && !rst;

`ifdef PACKETIZER_SEQNUM_EN
  logic [7:0] r_seq;
  logic       w_head_load;

  assign w_head_load = cmd_valid && w_cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_seq <= '0;
    else if (w_head_load) r_seq <= r_seq + 8'd1;
  end
`endif

  // Head payload: dest in the low field, source id above it.
  // Everything else is zero unless the sequence number is enabled.
  always_comb begin
    w_head_pl                = '0;
    w_head_pl[DW-1:0]        = cmd_dest;
    w_head_pl[2*DW-1:DW]     = DW'(INDEX);
`ifdef PACKETIZER_SEQNUM_EN
    w_head_pl[23:16]         = r_seq;
`endif
  end

  // FSM state and packet word counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_flit      = r_data;
    w_cmd_ready = 1'b0;
    w_pl_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = w_out_free;
        if (cmd_valid && w_out_free) begin
          w_load      = 1'b1;
          w_flit      = {T_HEAD, w_head_pl};
          w_cnt_nxt   = '0;
          w_state_nxt = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        w_pl_ready = w_out_free;
        if (pl_valid && w_out_free) begin
          w_load    = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
          // With FlitPerPacket == 2, LAST_BODY is 0 and the first word is
          // already the tail.
          if (r_cnt < LAST_BODY) begin
            w_flit = {T_BODY, pl_data};
          end else begin
            w_flit      = {T_TAIL, pl_data};
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output register: a load takes priority. An accepted flit with nothing
  // new behind it drops valid. A stalled flit keeps its data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= w_flit;
    end else if (ready_out) begin
      r_valid <= 1'b0;
    end
  end

  assign w_tail_xfer = r_valid && ready_out &&
                       (r_data[DATA_WIDTH-1 -: TYPE_WIDTH] == T_TAIL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_pkt_count <= '0;
    else if (w_tail_xfer) r_pkt_count <= r_pkt_count + 16'd1;
  end

  assign cmd_ready = w_cmd_ready;
  assign pl_ready  = w_pl_ready;
  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign busy      = (r_state == S_PAYLOAD);
  assign pkt_count = r_pkt_count;

endmodule
